// File: rtl/float_alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency float add/sub unit between NUM_REQ requesters.
// Operands are exponent-ordered before issue; results return through per-requester response registers.
module float_alu_arbiter #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 7,
  parameter int NUM_REQ   = 4,
  parameter int LAT       = 3,
  localparam int FW       = EXP_WIDTH + MAN_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*FW-1:0] req_lhs,
  input  logic [NUM_REQ*FW-1:0] req_rhs,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic                  alu_valid,
  output logic [FW-1:0]         alu_lhs,
  output logic [FW-1:0]         alu_rhs,
  output logic                  alu_sub,
  input  logic                  alu_res_valid,
  input  logic [FW-1:0]         alu_res,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*FW-1:0] rsp_data,
  output logic                  err
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    busy_q, busy_d, eligible;
  logic [IW-1:0]         ptr_q, ptr_d, gnt_idx, scan_idx;
  logic                  gnt_vld;
  logic [FW-1:0]         gnt_a, gnt_b;
  logic                  gnt_sub, gnt_swap;

  logic                  alu_valid_q, alu_sub_q;
  logic [FW-1:0]         alu_lhs_q, alu_rhs_q;
  logic [IW-1:0]         iss_idx_q;
  logic                  iss_flip_q;

  logic [LAT-1:0]        tag_v_q, tag_flip_q;
  logic [IW-1:0]         tag_idx_q [LAT];
  logic [IW-1:0]         last_idx;
  logic                  last_flip;

  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*FW-1:0] rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;

  assign eligible = req_valid & ~busy_q & {NUM_REQ{~rst}};

  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IW'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_vld && eligible[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // Strict compare: equal exponents keep the original operand order.
  always_comb begin
    gnt_a    = req_lhs[gnt_idx*FW +: FW];
    gnt_b    = req_rhs[gnt_idx*FW +: FW];
    gnt_sub  = req_sub[gnt_idx];
    gnt_swap = gnt_a[FW-2 -: EXP_WIDTH] < gnt_b[FW-2 -: EXP_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid_q <= 1'b0;
      alu_lhs_q   <= '0;
      alu_rhs_q   <= '0;
      alu_sub_q   <= 1'b0;
      iss_idx_q   <= '0;
      iss_flip_q  <= 1'b0;
    end else begin
      alu_valid_q <= gnt_vld;
      if (gnt_vld) begin
        alu_lhs_q  <= gnt_swap ? gnt_b : gnt_a;
        alu_rhs_q  <= gnt_swap ? gnt_a : gnt_b;
        alu_sub_q  <= gnt_sub;
        iss_idx_q  <= gnt_idx;
        iss_flip_q <= gnt_swap & gnt_sub;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q    <= '0;
      tag_flip_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_idx_q[i] <= '0;
    end else begin
      tag_v_q[0]    <= alu_valid_q;
      tag_flip_q[0] <= iss_flip_q;
      tag_idx_q[0]  <= iss_idx_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_flip_q[i] <= tag_flip_q[i-1];
        tag_idx_q[i]  <= tag_idx_q[i-1];
      end
    end
  end

  assign last_idx  = tag_idx_q[LAT-1];
  assign last_flip = tag_flip_q[LAT-1];

  // A tag with no matching result frees its requester so it cannot lock up.
  always_comb begin
    ptr_d       = ptr_q;
    busy_d      = busy_q & ~(rsp_valid_q & rsp_ready);
    rsp_valid_d = rsp_valid_q & ~(rsp_valid_q & rsp_ready);
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    if (gnt_vld) begin
      busy_d[gnt_idx] = 1'b1;
      ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (tag_v_q[LAT-1]) begin
      if (alu_res_valid) begin
        rsp_valid_d[last_idx] = 1'b1;
        rsp_data_d[last_idx*FW +: FW] = {alu_res[FW-1] ^ last_flip, alu_res[FW-2:0]};
      end else begin
        err_d            = 1'b1;
        busy_d[last_idx] = 1'b0;
      end
    end else if (alu_res_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_lhs   = alu_lhs_q;
  assign alu_rhs   = alu_rhs_q;
  assign alu_sub   = alu_sub_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_float_alu_arbiter.sv
// Directed bench for float_alu_arbiter with a stub LAT-cycle adder returning hand-picked results.
module tb_float_alu_arbiter;

  localparam int EW  = 8;
  localparam int MW  = 7;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int FW  = EW + MW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_sub;
  logic [NR*FW-1:0]  req_lhs, req_rhs;
  logic              alu_valid, alu_sub, alu_res_valid;
  logic [FW-1:0]     alu_lhs, alu_rhs, alu_res;
  logic [NR-1:0]     rsp_valid, rsp_ready;
  logic [NR*FW-1:0]  rsp_data;
  logic              err;

  logic              inj, kill;
  logic [LAT-1:0]    pv;
  logic [FW-1:0]     pr [LAT];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  float_alu_arbiter #(
    .EXP_WIDTH (EW),
    .MAN_WIDTH (MW),
    .NUM_REQ   (NR),
    .LAT       (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_lhs       (req_lhs),
    .req_rhs       (req_rhs),
    .req_sub       (req_sub),
    .alu_valid     (alu_valid),
    .alu_lhs       (alu_lhs),
    .alu_rhs       (alu_rhs),
    .alu_sub       (alu_sub),
    .alu_res_valid (alu_res_valid),
    .alu_res       (alu_res),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .err           (err)
  );

  // Stub adder: known bf16 cases return true results, anything else echoes alu_lhs.
  function automatic logic [FW-1:0] fake_add(input logic [FW-1:0] l, input logic [FW-1:0] r,
                                             input logic s);
    if (l == 16'h4000 && r == 16'h3F80 && s) return 16'h3F80;
    if (l == 16'h3FC0 && r == 16'h3F80 && s) return 16'h3F00;
    return l;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= alu_valid & ~kill;
      pr[0] <= fake_add(alu_lhs, alu_rhs, alu_sub);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end

  assign alu_res_valid = pv[LAT-1] | inj;
  assign alu_res       = pv[LAT-1] ? pr[LAT-1] : '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b, input logic s);
    req_lhs[i*FW +: FW] = a;
    req_rhs[i*FW +: FW] = b;
    req_sub[i]          = s;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_lhs = '0; req_rhs = '0; req_sub = '0;
    rsp_ready = '0; inj = 1'b0; kill = 1'b0;
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_alu_ops", {alu_sub, alu_lhs, alu_rhs}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // 1: 1.0 - 2.0 swaps operands, adder gives 1.0, sign flipped to -1.0
    set_op(0, 16'h3F80, 16'h4000, 1'b1);
    req_valid = 4'b0001;
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick();
    chk("t1_busy_ready", req_ready, 4'b0000);
    req_valid = '0;
    chk("t1_alu_valid", alu_valid, 1);
    chk("t1_alu_lhs", alu_lhs, 16'h4000);
    chk("t1_alu_rhs", alu_rhs, 16'h3F80);
    chk("t1_alu_sub", alu_sub, 1);
    tick();
    chk("t1_alu_pulse", alu_valid, 0);
    chk("t1_alu_hold", alu_lhs, 16'h4000);
    tick(); tick();
    chk("t1_rsp_early", rsp_valid, 4'b0000);
    tick();
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data[15:0], 16'hBF80);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    chk("t1_rsp_clear", rsp_valid, 4'b0000);

    // 2: equal exponents, no swap, no flip
    set_op(0, 16'h3FC0, 16'h3F80, 1'b1);
    req_valid = 4'b0001;
    #1 chk("t2_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t2_alu_lhs", alu_lhs, 16'h3FC0);
    chk("t2_alu_rhs", alu_rhs, 16'h3F80);
    tick(); tick(); tick(); tick();
    chk("t2_rsp_valid", rsp_valid, 4'b0001);
    chk("t2_rsp_data", rsp_data[15:0], 16'h3F00);

    // 3: back-to-back grants, no reissue while busy, re-grant after handshake
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 16'h4000 + 16'(i * 16'h0080), 16'h3F80, 1'b0);
    req_valid = 4'b1111;
    for (int g = 0; g < NR; g++) begin
      #1 chk("t3_grant", req_ready, 64'(1) << g);
      tick();
      chk("t3_issue_lhs", alu_lhs, 16'h4000 + 16'(g * 16'h0080));
    end
    #1 chk("t3_no_reissue", req_ready, 4'b0000);
    tick(); tick(); tick(); tick();
    chk("t3_rsp_all", rsp_valid, 4'b1111);
    chk("t3_rsp_data", rsp_data, 64'h4180_4100_4080_4000);
    rsp_ready = 4'b0010;
    #1 chk("t3_same_cycle", req_ready, 4'b0000);
    tick();
    rsp_ready = '0;
    #1 chk("t3_regrant", req_ready, 4'b0010);
    chk("t3_rsp_left", rsp_valid, 4'b1101);

    // 4: round-robin order after a grant to 2
    do_reset();
    req_valid = 4'b0100;
    #1 chk("t4_grant2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1001;
    #1 chk("t4_grant3", req_ready, 4'b1000);
    tick();
    #1 chk("t4_wrap0", req_ready, 4'b0001);
    tick();
    #1 chk("t4_all_busy", req_ready, 4'b0000);

    // 5: reset the cycle after a grant
    do_reset();
    req_valid = 4'b0010;
    tick();
    rst = 1'b1;
    req_valid = 4'b1111;
    #1 chk("t5_ready_in_rst", req_ready, 4'b0000);
    tick();
    chk("t5_alu_valid", alu_valid, 0);
    chk("t5_rsp_valid", rsp_valid, 4'b0000);
    rst = 1'b0;
    req_valid = 4'b0110;
    #1 chk("t5_lowest", req_ready, 4'b0010);
    req_valid = '0;
    repeat (6) tick();
    chk("t5_no_stale", rsp_valid, 4'b0000);
    chk("t5_no_err", err, 0);

    // 6: spurious result, then a missing result
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("t6_err_set", err, 1);
    chk("t6_no_rsp", rsp_valid, 4'b0000);
    repeat (3) tick();
    chk("t6_err_sticky", err, 1);
    do_reset();
    chk("t6_err_rst", err, 0);
    kill = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    kill = 1'b0;
    tick(); tick();
    chk("t6_drop_early", err, 0);
    tick();
    chk("t6_drop_err", err, 1);
    chk("t6_drop_rsp", rsp_valid, 4'b0000);
    req_valid = 4'b0001;
    #1 chk("t6_busy_freed", req_ready, 4'b0001);
    do_reset();
    chk("t6_err_clear", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
